// File: rtl/riscv_pkg.sv
// RV32I decode types, field encoders and their matching per-format decoders.
// Shared by the decode stage, its immediate generator and the execute stage.
package riscv_pkg;

  localparam int RV_XLEN     = 32;
  localparam int RV_PC_WIDTH = 32;

  typedef enum logic [6:0] {
    OP_LUI     = 7'h37,
    OP_AUIPC   = 7'h17,
    OP_JAL     = 7'h6F,
    OP_JALR    = 7'h67,
    OP_BRANCH  = 7'h63,
    OP_LOAD    = 7'h03,
    OP_STORE   = 7'h23,
    OP_REG_IMM = 7'h13,
    OP_REG_REG = 7'h33
  } opcode_t;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0,
    F3_SLL     = 3'd1,
    F3_SLT     = 3'd2,
    F3_SLTU    = 3'd3,
    F3_XOR     = 3'd4,
    F3_SRL_SRA = 3'd5,
    F3_OR      = 3'd6,
    F3_AND     = 3'd7
  } funct3_t;

  typedef enum logic [6:0] {
    F7_BASE = 7'h00,
    F7_ALT  = 7'h20
  } funct7_t;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  typedef struct packed {
    logic [6:0]             opcode;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [RV_PC_WIDTH-1:0] pc;
    logic [RV_XLEN-1:0]     reg_a;
    logic [RV_XLEN-1:0]     reg_b;
    logic [RV_XLEN-1:0]     imm;
  } decoded_instr_t;

  function automatic logic [31:0] encode_r_type(logic [6:0] funct7, logic [4:0] rs2, logic [4:0] rs1,
                                                logic [2:0] funct3, logic [4:0] rd, logic [6:0] opcode);
    return {funct7, rs2, rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] encode_i_type(logic [11:0] imm, logic [4:0] rs1, logic [2:0] funct3,
                                                logic [4:0] rd, logic [6:0] opcode);
    return {imm, rs1, funct3, rd, opcode};
  endfunction

  function automatic logic [31:0] encode_s_type(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                                logic [2:0] funct3, logic [6:0] opcode);
    return {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
  endfunction

  function automatic logic [31:0] encode_b_type(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                                logic [2:0] funct3, logic [6:0] opcode);
    return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  endfunction

  function automatic logic [31:0] encode_u_type(logic [19:0] imm, logic [4:0] rd, logic [6:0] opcode);
    return {imm, rd, opcode};
  endfunction

  function automatic logic [31:0] encode_j_type(logic [20:1] imm, logic [4:0] rd, logic [6:0] opcode);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
  endfunction

  // Decoders zero every field the format does not carry; funct3 is passed through raw.
  function automatic decoded_instr_t decode_r_type(logic [31:0] instr);
    decoded_instr_t d;
    d        = '0;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct7 = instr[31:25];
    return d;
  endfunction

  function automatic decoded_instr_t decode_i_type(logic [31:0] instr);
    decoded_instr_t d;
    d        = '0;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.imm    = {{(RV_XLEN-12){instr[31]}}, instr[31:20]};
    return d;
  endfunction

  function automatic decoded_instr_t decode_s_type(logic [31:0] instr);
    decoded_instr_t d;
    d        = '0;
    d.opcode = instr[6:0];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.imm    = {{(RV_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    return d;
  endfunction

  function automatic decoded_instr_t decode_b_type(logic [31:0] instr);
    decoded_instr_t d;
    d        = '0;
    d.opcode = instr[6:0];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.imm    = {{(RV_XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    return d;
  endfunction

  function automatic decoded_instr_t decode_u_type(logic [31:0] instr);
    decoded_instr_t d;
    d        = '0;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.imm    = {{(RV_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    return d;
  endfunction

  function automatic decoded_instr_t decode_j_type(logic [31:0] instr);
    decoded_instr_t d;
    d        = '0;
    d.opcode = instr[6:0];
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.imm    = {{(RV_XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return d;
  endfunction

  // Unknown opcodes fall back to R so every raw field stays visible for debug.
  function automatic imm_type_t imm_type_of(logic [6:0] opcode);
    case (opcode)
      OP_REG_IMM, OP_LOAD, OP_JALR: return IMM_I;
      OP_STORE:                     return IMM_S;
      OP_BRANCH:                    return IMM_B;
      OP_LUI, OP_AUIPC:             return IMM_U;
      OP_JAL:                       return IMM_J;
      default:                      return IMM_R;
    endcase
  endfunction

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch-side, register-file, write-back and execute-side signals of the decode stage.
// slave is the decode stage itself; master is whatever surrounds it.
interface riscv_decode_stage_if #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_instr;
  logic [PC_WIDTH-1:0]        in_pc;
  logic [4:0]                 rf_raddr1;
  logic [4:0]                 rf_raddr2;
  logic [XLEN-1:0]            rf_rdata1;
  logic [XLEN-1:0]            rf_rdata2;
  logic                       wb_we;
  logic [4:0]                 wb_addr;
  logic [XLEN-1:0]            wb_data;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  riscv_pkg::decoded_instr_t  out_instr;
  riscv_pkg::imm_type_t       out_imm_type;
  logic                       out_reg_write;
  logic                       out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2,
           wb_we, wb_addr, wb_data, flush, out_ready,
    output in_ready, rf_raddr1, rf_raddr2,
           out_valid, out_instr, out_imm_type, out_reg_write, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rf_rdata1, rf_rdata2,
           wb_we, wb_addr, wb_data, flush, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2,
           out_valid, out_instr, out_imm_type, out_reg_write, out_illegal
  );

endinterface

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and
// returns the sign-extended immediate for it (zero for R-type and unknown opcodes).
module riscv_imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0]        instr,
  output logic [RV_XLEN-1:0] imm,
  output imm_type_t          imm_type
);

  always_comb begin
    imm_type = imm_type_of(instr[6:0]);
    case (imm_type)
      IMM_I:   imm = decode_i_type(instr).imm;
      IMM_S:   imm = decode_s_type(instr).imm;
      IMM_B:   imm = decode_b_type(instr).imm;
      IMM_U:   imm = decode_u_type(instr).imm;
      IMM_J:   imm = decode_j_type(instr).imm;
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I ID stage: field split, immediate, operand read with same-cycle write-back
// bypass, legality check; one register slice with valid/ready, stall and flush.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = RV_XLEN,
  parameter int PC_WIDTH = RV_PC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_decode_stage_if.slave  dif
);

  logic [31:0]         instr;
  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [XLEN-1:0]     imm;
  imm_type_t           imm_type;
  decoded_instr_t      dec;
  logic [XLEN-1:0]     reg_a;
  logic [XLEN-1:0]     reg_b;
  logic [PC_WIDTH-1:0] pc;
  logic                illegal;
  logic                has_rd;
  logic                in_ready;
  logic                accept;

  logic                out_valid_d,     out_valid_q;
  decoded_instr_t      out_instr_d,     out_instr_q;
  imm_type_t           out_imm_type_d,  out_imm_type_q;
  logic                out_reg_write_d, out_reg_write_q;
  logic                out_illegal_d,   out_illegal_q;

  assign instr  = dif.in_instr;
  assign pc     = dif.in_pc;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Raw address bits go to the register file so the read overlaps decode.
  assign dif.rf_raddr1 = instr[19:15];
  assign dif.rf_raddr2 = instr[24:20];

  riscv_imm_gen u_imm_gen (
    .instr    (instr),
    .imm      (imm),
    .imm_type (imm_type)
  );

  always_comb begin
    dec = decode_r_type(instr);
    case (imm_type)
      IMM_I:   dec = decode_i_type(instr);
      IMM_S:   dec = decode_s_type(instr);
      IMM_B:   dec = decode_b_type(instr);
      IMM_U:   dec = decode_u_type(instr);
      IMM_J:   dec = decode_j_type(instr);
      default: dec = decode_r_type(instr);
    endcase
    // Shift-immediates carry the arithmetic/logical selector in funct7.
    if (opcode == OP_REG_IMM && (f3 == F3_SLL || f3 == F3_SRL_SRA))
      dec.funct7 = f7;
    dec.imm = imm;
    dec.pc  = pc;
  end

  always_comb begin
    if (dec.rs1 == 5'd0)                           reg_a = '0;
    else if (dif.wb_we && dif.wb_addr == dec.rs1)  reg_a = dif.wb_data;
    else                                           reg_a = dif.rf_rdata1;
    if (dec.rs2 == 5'd0)                           reg_b = '0;
    else if (dif.wb_we && dif.wb_addr == dec.rs2)  reg_b = dif.wb_data;
    else                                           reg_b = dif.rf_rdata2;
  end

  always_comb begin
    illegal = 1'b0;
    has_rd  = 1'b1;
    case (opcode)
      OP_REG_REG: illegal = !(f7 == F7_BASE || f7 == F7_ALT) ||
                            (f7 == F7_ALT && !(f3 == F3_ADD_SUB || f3 == F3_SRL_SRA));
      OP_REG_IMM: illegal = (f3 == F3_SLL && f7 != F7_BASE) ||
                            (f3 == F3_SRL_SRA && !(f7 == F7_BASE || f7 == F7_ALT));
      OP_LOAD:    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      OP_STORE: begin
        illegal = (f3 > 3'd2);
        has_rd  = 1'b0;
      end
      OP_BRANCH: begin
        illegal = (f3 == 3'd2) || (f3 == 3'd3);
        has_rd  = 1'b0;
      end
      OP_JALR:    illegal = (f3 != 3'd0);
      OP_LUI, OP_AUIPC, OP_JAL: illegal = 1'b0;
      default: begin
        illegal = 1'b1;
        has_rd  = 1'b0;
      end
    endcase
  end

  assign in_ready = !out_valid_q || dif.out_ready;
  assign accept   = dif.in_valid && in_ready;

  always_comb begin
    out_valid_d     = out_valid_q;
    out_instr_d     = out_instr_q;
    out_imm_type_d  = out_imm_type_q;
    out_reg_write_d = out_reg_write_q;
    out_illegal_d   = out_illegal_q;
    if (dif.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d       = 1'b1;
      out_instr_d       = dec;
      out_instr_d.reg_a = reg_a;
      out_instr_d.reg_b = reg_b;
      out_imm_type_d    = imm_type;
      out_reg_write_d   = !illegal && has_rd && (dec.rd != 5'd0);
      out_illegal_d     = illegal;
    end else if (dif.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_instr_q     <= '0;
      out_imm_type_q  <= IMM_R;
      out_reg_write_q <= 1'b0;
      out_illegal_q   <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_instr_q     <= out_instr_d;
      out_imm_type_q  <= out_imm_type_d;
      out_reg_write_q <= out_reg_write_d;
      out_illegal_q   <= out_illegal_d;
    end
  end

  assign dif.in_ready      = in_ready;
  assign dif.out_valid     = out_valid_q;
  assign dif.out_instr     = out_instr_q;
  assign dif.out_imm_type  = out_imm_type_q;
  assign dif.out_reg_write = out_reg_write_q;
  assign dif.out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Table of instruction vectors with hand-derived expectations, a scoreboard queue
// popped on every output handshake, and hand sequences for stall, flush and reset.
module tb_riscv_decode_stage;
  import riscv_pkg::*;

  typedef struct packed {
    decoded_instr_t instr;
    imm_type_t      it;
    logic           rw;
    logic           ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  riscv_decode_stage_if #(.XLEN(32), .PC_WIDTH(32)) dif ();

  riscv_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic exp_t mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] f3, logic [6:0] f7, logic [31:0] ra, logic [31:0] rb,
                              logic [31:0] imm, imm_type_t it, logic rw, logic ill);
    exp_t e;
    e = '0;
    e.instr.opcode = op;  e.instr.rd = rd;    e.instr.rs1 = rs1;  e.instr.rs2 = rs2;
    e.instr.funct3 = f3;  e.instr.funct7 = f7;
    e.instr.reg_a  = ra;  e.instr.reg_b = rb; e.instr.imm = imm;
    e.it = it;  e.rw = rw;  e.ill = ill;
    return e;
  endfunction

  task automatic add(input logic [31:0] instr, input logic [31:0] rf1, input logic [31:0] rf2,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
    vec_t v;
    v.instr = instr; v.rf1 = rf1; v.rf2 = rf2; v.we = we; v.wa = wa; v.wd = wd; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc);
    dif.in_valid  = 1'b1;
    dif.in_instr  = v.instr;
    dif.in_pc     = pc;
    dif.rf_rdata1 = v.rf1;
    dif.rf_rdata2 = v.rf2;
    dif.wb_we     = v.we;
    dif.wb_addr   = v.wa;
    dif.wb_data   = v.wd;
  endtask

  task automatic idle();
    dif.in_valid = 1'b0;
    dif.wb_we    = 1'b0;
  endtask

  function automatic exp_t with_pc(input exp_t e, input logic [31:0] pc);
    exp_t r;
    r = e;
    r.instr.pc = pc;
    return r;
  endfunction

  // Pushes the expectation on the cycle the handshake completes, then steps past the edge.
  task automatic wait_accept(input exp_t e);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (dif.in_ready) begin
        if (!dif.flush) sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose for pc %h", e.instr.pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 192'(sb.size()), 192'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && dif.out_valid && dif.out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: pc %h with nothing outstanding", dif.out_instr.pc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("out_pc_%h", e.instr.pc),
            192'({dif.out_instr, dif.out_imm_type, dif.out_reg_write, dif.out_illegal}), 192'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t ea, eb;
    logic [31:0] pc;

    add(32'h00500093, 32'hAAAA, 32'hBBBB, 0, 0, 0,
        mk(7'h13, 1, 0, 0, 0, 7'h00, 0, 0, 32'd5, IMM_I, 1, 0));
    add(32'h402081B3, 32'd10, 32'd3, 0, 0, 0,
        mk(7'h33, 3, 1, 2, 0, 7'h20, 32'd10, 32'd3, 0, IMM_R, 1, 0));
    add(32'h402081B3, 32'd10, 32'd3, 1, 5'd2, 32'd7,
        mk(7'h33, 3, 1, 2, 0, 7'h20, 32'd10, 32'd7, 0, IMM_R, 1, 0));
    add(32'h0020A423, 32'd100, 32'd200, 0, 0, 0,
        mk(7'h23, 0, 1, 2, 2, 7'h00, 32'd100, 32'd200, 32'd8, IMM_S, 0, 0));
    add(32'hFE208EE3, 32'd5, 32'd6, 0, 0, 0,
        mk(7'h63, 0, 1, 2, 0, 7'h00, 32'd5, 32'd6, 32'hFFFFFFFC, IMM_B, 0, 0));
    add(32'h008000EF, 32'h11, 32'h22, 0, 0, 0,
        mk(7'h6F, 1, 0, 0, 0, 7'h00, 0, 0, 32'd8, IMM_J, 1, 0));
    add(32'h123452B7, 32'd1, 32'd2, 0, 0, 0,
        mk(7'h37, 5, 0, 0, 5, 7'h00, 0, 0, 32'h12345000, IMM_U, 1, 0));
    add(32'h0000007F, 32'd3, 32'd4, 0, 0, 0,
        mk(7'h7F, 0, 0, 0, 0, 7'h00, 0, 0, 0, IMM_R, 0, 1));
    add(32'h800081B3, 32'd9, 32'd8, 0, 0, 0,
        mk(7'h33, 3, 1, 0, 0, 7'h40, 32'd9, 0, 0, IMM_R, 0, 1));
    add(32'h4030D213, 32'h80000000, 32'h1234, 1, 5'd1, 32'h55,
        mk(7'h13, 4, 1, 0, 5, 7'h20, 32'h55, 0, 32'h403, IMM_I, 1, 0));
    add(32'h00208033, 32'd1, 32'd2, 1, 5'd0, 32'hDEAD,
        mk(7'h33, 0, 1, 2, 0, 7'h00, 32'd1, 32'd2, 0, IMM_R, 0, 0));
    add(32'h40309093, 32'd7, 32'd9, 0, 0, 0,
        mk(7'h13, 1, 1, 0, 1, 7'h20, 32'd7, 0, 32'h403, IMM_I, 0, 1));
    add(32'h000110E7, 32'h33, 32'h44, 0, 0, 0,
        mk(7'h67, 1, 2, 0, 1, 7'h00, 32'h33, 0, 0, IMM_I, 0, 1));
    add(32'h00003003, 32'd5, 32'd6, 0, 0, 0,
        mk(7'h03, 0, 0, 0, 3, 7'h00, 0, 0, 0, IMM_I, 0, 1));
    add(32'hFFFFF117, 32'd5, 32'd6, 0, 0, 0,
        mk(7'h17, 2, 0, 0, 7, 7'h00, 0, 0, 32'hFFFFF000, IMM_U, 1, 0));
    add(32'h00003023, 32'd5, 32'd6, 0, 0, 0,
        mk(7'h23, 0, 0, 0, 3, 7'h00, 0, 0, 0, IMM_S, 0, 1));
    add(32'h00002063, 32'd5, 32'd6, 0, 0, 0,
        mk(7'h63, 0, 0, 0, 2, 7'h00, 0, 0, 0, IMM_B, 0, 1));
    add(32'hFF812303, 32'h1000, 32'h77, 1, 5'd3, 32'd9,
        mk(7'h03, 6, 2, 0, 2, 7'h00, 32'h1000, 0, 32'hFFFFFFF8, IMM_I, 1, 0));

    dif.in_valid = 0; dif.in_instr = 0; dif.in_pc = 0; dif.rf_rdata1 = 0; dif.rf_rdata2 = 0;
    dif.wb_we = 0; dif.wb_addr = 0; dif.wb_data = 0; dif.flush = 0; dif.out_ready = 1;

    @(negedge clk);
    chk("reset_state", 192'({dif.out_valid, dif.out_instr, dif.out_imm_type, dif.out_reg_write, dif.out_illegal}),
        192'({1'b0, 160'd0, IMM_R, 1'b0, 1'b0}));
    @(posedge clk); #1 rst = 0;

    // Single addi: visible exactly one edge after the accept.
    @(posedge clk); #1;
    drive(vecs[0], 32'h100);
    wait_accept(with_pc(vecs[0].e, 32'h100));
    idle();
    @(negedge clk);
    chk("latency_one_cycle", 192'(dif.out_valid), 192'd1);
    drain();

    // Back-to-back table stream with the consumer always ready.
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      pc = 32'h1000 + 32'(i) * 4;
      drive(vecs[i], pc);
      wait_accept(with_pc(vecs[i].e, pc));
    end
    idle();
    drain();

    // Stall: consumer blocks three cycles while the next instruction waits.
    dif.out_ready = 0;
    @(posedge clk); #1;
    drive(vecs[1], 32'h2000);
    #1 chk("rf_raddr", 192'({dif.rf_raddr1, dif.rf_raddr2}), 192'({5'd1, 5'd2}));
    ea = with_pc(vecs[1].e, 32'h2000);
    wait_accept(ea);
    drive(vecs[3], 32'h2004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 192'(dif.in_ready), 192'd0);
      chk("stall_hold", 192'({dif.out_valid, dif.out_instr, dif.out_imm_type}), 192'({1'b1, ea.instr, ea.it}));
    end
    @(posedge clk); #1 dif.out_ready = 1;
    wait_accept(with_pc(vecs[3].e, 32'h2004));
    drive(vecs[4], 32'h2008);
    wait_accept(with_pc(vecs[4].e, 32'h2008));
    idle();
    drain();

    // Flush concurrent with an accept into an empty stage: the entry is discarded.
    @(posedge clk); #1;
    drive(vecs[5], 32'h3000);
    dif.flush = 1;
    @(negedge clk);
    chk("flush_in_ready", 192'(dif.in_ready), 192'd1);
    @(posedge clk); #1;
    dif.flush = 0;
    idle();
    @(negedge clk);
    chk("flush_accept_dropped", 192'(dif.out_valid), 192'd0);

    // Flush of a held entry.
    dif.out_ready = 0;
    @(posedge clk); #1;
    drive(vecs[6], 32'h3004);
    wait_accept(with_pc(vecs[6].e, 32'h3004));
    idle();
    @(negedge clk);
    chk("held_before_flush", 192'(dif.out_valid), 192'd1);
    @(posedge clk); #1 dif.flush = 1;
    @(posedge clk); #1 dif.flush = 0;
    @(negedge clk);
    chk("held_flushed", 192'(dif.out_valid), 192'd0);
    if (sb.size() != 0) void'(sb.pop_back());
    dif.out_ready = 1;

    // Reset mid-transfer drops the entry at once.
    dif.out_ready = 0;
    @(posedge clk); #1;
    drive(vecs[9], 32'h4000);
    wait_accept(with_pc(vecs[9].e, 32'h4000));
    idle();
    @(negedge clk); #2 rst = 1;
    #1 chk("async_reset", 192'({dif.out_valid, dif.out_instr, dif.out_imm_type, dif.out_reg_write, dif.out_illegal}),
           192'({1'b0, 160'd0, IMM_R, 1'b0, 1'b0}));
    sb.delete();
    @(posedge clk); #1 rst = 0;
    dif.out_ready = 1;

    // Recovery after reset.
    @(posedge clk); #1;
    eb = with_pc(vecs[17].e, 32'h5000);
    drive(vecs[17], 32'h5000);
    wait_accept(eb);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Pipelined RV32I instruction decoder, the ID stage between fetch and execute. Accepts a raw 32-bit instruction word and its PC over a valid/ready handshake and splits it into opcode/rd/rs1/rs2/funct3/funct7 fields. Generates the sign-extended immediate for all six formats and reads both source operands from the register file, with write-back bypass. It registers the result as a `decoded_instr_t` for the execute stage, one cycle later, with stall and flush support. It is the inverse of the package's `encode_*_type` functions: every word those functions build must decode back to its original fields.

## Interface
Parameters:
- `XLEN`, 32, register and immediate width
- `PC_WIDTH`, 32, program counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  fetch offers `in_instr`/`in_pc`
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  raw instruction word
- `in_pc`  in  PC_WIDTH  PC of `in_instr`
- `rf_raddr1`, `rf_raddr2`  out  5  register-file read addresses (combinational from `in_instr[19:15]` and `in_instr[24:20]`)
- `rf_rdata1`, `rf_rdata2`  in  XLEN  register-file read data, same cycle
- `wb_we`  in  1  write-back write enable
- `wb_addr`  in  5  write-back destination
- `wb_data`  in  XLEN  write-back value
- `flush`  in  1  squash the held entry and any entry being accepted
- `out_valid`  out  1  `out_instr` is valid
- `out_ready`  in  1  execute accepts `out_instr`
- `out_instr`  out  decoded_instr_t  decoded fields, PC, reg_A, reg_B, immediate
- `out_imm_type`  out  imm_type_t  which format produced the immediate
- `out_reg_write`  out  1  instruction writes rd (rd ≠ x0 and the format has rd)
- `out_illegal`  out  1  instruction is not a legal RV32I encoding

## Operation
- Format selection by opcode:
  - REG_REG → R
  - REG_IMM, LOAD, JALR → I
  - STORE → S
  - BRANCH → B
  - LUI, AUIPC → U
  - JAL → J
- Immediate assembly, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
  - R: 0
- Field masking:
  - rs2 = 0 for I/U/J.
  - rs1 = 0 for U/J.
  - rd = 0 for S/B.
  - funct7 = 0 except for R-type and REG_IMM shifts.
- Operands:
  - reg_A = 0 if rs1 = 0.
  - Otherwise reg_A = wb_data if wb_we && wb_addr == rs1; otherwise rf_rdata1.
  - reg_B follows the same rule with rs2.
- Illegal when any of the following holds:
  - opcode is not in `opcode_t`;
  - R-type funct7 ∉ {0x00, 0x20}, or funct7 = 0x20 with funct3 ∉ {ADD_SUB, SRL_SRA};
  - REG_IMM SLL with funct7 ≠ 0, or SRL_SRA with funct7 ∉ {0x00, 0x20};
  - LOAD funct3 ∈ {3, 6, 7};
  - STORE funct3 > 2;
  - BRANCH funct3 ∈ {2, 3};
  - JALR funct3 ≠ 0.
- Illegal instructions still flow through with `out_illegal` = 1 and `out_reg_write` = 0.

## Timing
- Latency: 1 cycle, from accept (in_valid && in_ready at the edge) to out_valid.
- `in_ready = !out_valid || out_ready`, so a full pipe with the consumer accepting sustains 1 instr/cycle.
- Hold: while out_valid && !out_ready, every output is stable and in_ready = 0.
- flush:
  - On the next edge, out_valid ← 0 and any simultaneous accept is discarded; flush beats load.
  - in_ready is unaffected by flush.
- Reset, async: out_valid = 0, out_instr = '0, out_imm_type = IMM_R, out_reg_write = 0, out_illegal = 0. Reset asserted mid-transfer drops the entry.
- Bypass applies to a write-back in the same cycle as the accept. A write-back after the accept does not update a held entry; the hazard unit must stall upstream.

## Structure
- `riscv_pkg` additions:
  - `imm_type_t` enum {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J};
  - widen `decoded_instr_t.imm` to XLEN;
  - fix the funct7 enum to unique values F7_BASE = 0x00, F7_ALT = 0x20;
  - a `decode_*` function per format, mirroring `encode_*`.
- Sub-module `riscv_imm_gen`: combinational, instr → {imm, imm_type}; instantiated once.

## Test plan
- 0x00500093 (addi x1,x0,5) → opcode REG_IMM, rd=1, rs1=0, imm=5, IMM_I, reg_write=1, out_valid one cycle after accept.
- 0x402081B3 (sub x3,x1,x2) with rf x1=10, x2=3 → funct7=0x20, reg_A=10, reg_B=3; repeat with wb_we writing x2=7 in the same cycle → reg_B=7.
- 0x0020A423 (sw x2,8(x1)) → imm=8, rd=0, reg_write=0; 0xFE208EE3 (beq x1,x2,-4) → imm=0xFFFFFFFC, IMM_B.
- 0x008000EF (jal x1,8) → imm=8, rs1=rs2=0; 0x123452B7 (lui x5,0x12345) → imm=0x12345000.
- Back-to-back stream with out_ready low for 3 cycles → in_ready low, outputs frozen, no instruction lost or duplicated; flush concurrent with an accept → out_valid=0 next cycle.
- 0x0000007F and 0x800081B3 (bad funct7) → out_illegal=1, reg_write=0; rst asserted mid-stream → out_valid=0 immediately.
